// File: rtl/i2c_target.sv
// I2C target endpoint: synchronises SCL/SDA, detects START/STOP, matches a 7-bit address,
// streams written bytes out on rx_* and serves read bytes fetched from tx_*.
module i2c_target #(
    parameter logic [6:0] ADDR     = 7'h42,
    parameter int         HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    localparam int            HW        = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WR_BYTE   = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_RD_BYTE   = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic [2:0]    scl_sync_q, scl_sync_d;
    logic [2:0]    sda_sync_q, sda_sync_d;
    logic [2:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          pend_q, pend_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          busy_q, busy_d;

    logic scl_s, scl_h, sda_s, sda_h;
    logic start_det, stop_det, scl_rise, scl_fall;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
        scl_s      = scl_sync_q[1];
        scl_h      = scl_sync_q[2];
        sda_s      = sda_sync_q[1];
        sda_h      = sda_sync_q[2];
        start_det  = scl_s & scl_h & sda_h & ~sda_s;
        stop_det   = scl_s & scl_h & ~sda_h & sda_s;
        // A START/STOP on the same clk as an SCL edge takes precedence over the edge.
        scl_rise   = scl_s & ~scl_h & ~start_det & ~stop_det;
        scl_fall   = ~scl_s & scl_h & ~start_det & ~stop_det;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        pend_d     = pend_q;
        hold_cnt_d = hold_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        tx_req     = 1'b0;

        // Every SDA change requested at an SCL edge is applied HOLD_CYC clk later.
        if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
            if (hold_cnt_q == HW'(1)) begin
                sda_oe_d = pend_q;
            end
        end

        if (stop_det) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = 1'b0;
            hold_cnt_d = '0;
            busy_d     = 1'b0;
        end else if (start_det) begin
            state_d    = S_ADDR;
            bit_cnt_d  = 4'd0;
            pend_d     = 1'b0;
            hold_cnt_d = HOLD_LOAD;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == ADDR && shift_q[7:1] != 7'h00) begin
                            state_d    = S_ADDR_ACK;
                            rw_d       = shift_q[0];
                            busy_d     = 1'b1;
                            pend_d     = 1'b1;
                            hold_cnt_d = HOLD_LOAD;
                        end else begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d  = 4'd0;
                        hold_cnt_d = HOLD_LOAD;
                        if (rw_q) begin
                            tx_req  = 1'b1;
                            shift_d = tx_data;
                            pend_d  = ~tx_data[7];
                            state_d = S_RD_BYTE;
                        end else begin
                            pend_d  = 1'b0;
                            state_d = S_WR_BYTE;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d    = S_WR_ACK;
                        pend_d     = 1'b1;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        state_d    = S_WR_BYTE;
                        bit_cnt_d  = 4'd0;
                        pend_d     = 1'b0;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        hold_cnt_d = HOLD_LOAD;
                        if (bit_cnt_q == 4'd7) begin
                            state_d   = S_RD_ACK;
                            bit_cnt_d = 4'd0;
                            pend_d    = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            pend_d    = ~shift_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    // bit_cnt doubles as the "initiator ACKed" flag between the rise and fall.
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d    = S_WAIT_STOP;
                            sda_oe_d   = 1'b0;
                            hold_cnt_d = '0;
                            busy_d     = 1'b0;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        tx_req     = 1'b1;
                        shift_d    = tx_data;
                        pend_d     = ~tx_data[7];
                        hold_cnt_d = HOLD_LOAD;
                        bit_cnt_d  = 4'd0;
                        state_d    = S_RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            pend_q     <= 1'b0;
            hold_cnt_q <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            pend_q     <= pend_d;
            hold_cnt_q <= hold_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged open-drain initiator driven from a table of bus operations.
module tb_i2c_target;
    localparam logic [2:0] OP_START  = 3'd0;
    localparam logic [2:0] OP_RSTART = 3'd1;
    localparam logic [2:0] OP_STOP   = 3'd2;
    localparam logic [2:0] OP_WR     = 3'd3;
    localparam logic [2:0] OP_RD     = 3'd4;

    // data: byte written (WR) or byte expected back (RD).
    // ack:  expected target ACK (WR) or ACK the initiator sends (RD).
    // rxv/txr: cumulative rx_valid / tx_req pulse counts expected after the op.
    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       ack;
        logic       busy;
        logic       chk_rx;
        logic [7:0] exp_rx;
        int         rxv;
        int         txr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    logic [7:0] tx_tab [8];
    int         tx_idx      = 0;
    int         rxv_cnt     = 0;
    int         oe_cnt      = 0;
    int         overlap_cnt = 0;
    int         long_rxv    = 0;
    logic       rxv_prev    = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    assign sda_line = sda_m & ~sda_oe;
    assign tx_data  = tx_tab[tx_idx];

    i2c_target dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (rx_valid) rxv_cnt <= rxv_cnt + 1;
            if (tx_req) tx_idx <= tx_idx + 1;
            if (sda_oe) oe_cnt <= oe_cnt + 1;
            if (rx_valid && tx_req) overlap_cnt <= overlap_cnt + 1;
            if (rx_valid && rxv_prev) long_rxv <= long_rxv + 1;
            rxv_prev <= rx_valid;
        end else begin
            rxv_prev <= 1'b0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_bit(input logic b_out, output logic b_in);
        sda_m = b_out;
        wait_clk(10);
        scl_m = 1'b1;
        wait_clk(5);
        b_in = sda_line;
        wait_clk(5);
        scl_m = 1'b0;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        logic a;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], dummy);
        i2c_bit(1'b1, a);
        ack = ~a;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] d);
        logic bit_in;
        logic dummy;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, bit_in);
            d = {d[6:0], bit_in};
        end
        i2c_bit(~send_ack, dummy);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       ack;
        logic [7:0] d;
        string      tag;
        tag = $sformatf("v%0d", idx);
        case (v.op)
            OP_START: begin
                sda_m = 1'b1; scl_m = 1'b1; wait_clk(10);
                sda_m = 1'b0; wait_clk(10);
                scl_m = 1'b0; wait_clk(10);
            end
            OP_RSTART: begin
                sda_m = 1'b1; wait_clk(10);
                scl_m = 1'b1; wait_clk(10);
                sda_m = 1'b0; wait_clk(10);
                scl_m = 1'b0; wait_clk(10);
            end
            OP_STOP: begin
                sda_m = 1'b0; wait_clk(10);
                scl_m = 1'b1; wait_clk(10);
                sda_m = 1'b1; wait_clk(10);
            end
            OP_WR: begin
                write_byte(v.data, ack);
                chk({tag, "_ack"}, 32'(ack), 32'(v.ack));
            end
            default: begin
                read_byte(v.ack, d);
                chk({tag, "_rd_data"}, 32'(d), 32'(v.data));
            end
        endcase
        chk({tag, "_busy"}, 32'(busy), 32'(v.busy));
        chk({tag, "_rx_valid_cnt"}, rxv_cnt, v.rxv);
        chk({tag, "_tx_req_cnt"}, tx_idx, v.txr);
        if (v.chk_rx) chk({tag, "_rx_data"}, 32'(rx_data), 32'(v.exp_rx));
    endtask

    vec_t vecs [20];
    vec_t hv;
    int   oe_mark;

    initial begin
        // Main table: write A5, read 3C with NACK, read 01/FF, write 55 + repeated START read.
        vecs[0]  = '{OP_START,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
        vecs[1]  = '{OP_WR,     8'h84, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
        vecs[2]  = '{OP_WR,     8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1, 0};
        vecs[3]  = '{OP_STOP,   8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 0};
        vecs[4]  = '{OP_START,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0};
        vecs[5]  = '{OP_WR,     8'h85, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1};
        vecs[6]  = '{OP_RD,     8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1};
        vecs[7]  = '{OP_STOP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1};
        vecs[8]  = '{OP_START,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1};
        vecs[9]  = '{OP_WR,     8'h85, 1'b1, 1'b1, 1'b0, 8'h00, 1, 2};
        vecs[10] = '{OP_RD,     8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1, 3};
        vecs[11] = '{OP_RD,     8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1, 3};
        vecs[12] = '{OP_STOP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 3};
        vecs[13] = '{OP_START,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 3};
        vecs[14] = '{OP_WR,     8'h84, 1'b1, 1'b1, 1'b0, 8'h00, 1, 3};
        vecs[15] = '{OP_WR,     8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 2, 3};
        vecs[16] = '{OP_RSTART, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2, 3};
        vecs[17] = '{OP_WR,     8'h85, 1'b1, 1'b1, 1'b1, 8'h55, 2, 4};
        vecs[18] = '{OP_RD,     8'h96, 1'b0, 1'b0, 1'b0, 8'h00, 2, 4};
        vecs[19] = '{OP_STOP,   8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 2, 4};

        tx_tab[0] = 8'h3C; tx_tab[1] = 8'h01; tx_tab[2] = 8'hFF; tx_tab[3] = 8'h96;
        tx_tab[4] = 8'h7E; tx_tab[5] = 8'h00; tx_tab[6] = 8'h00; tx_tab[7] = 8'h00;

        // Clock/reset
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        chk("rst_sda_oe",   32'(sda_oe),   32'd0);
        chk("rst_rx_data",  32'(rx_data),  32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_req",   32'(tx_req),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

        // Address 7'h48 is not ours: no ACK, no data, SDA never driven.
        oe_mark = oe_cnt;
        hv = '{OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2, 4}; run_vec(hv, 100);
        hv = '{OP_WR,    8'h90, 1'b0, 1'b0, 1'b0, 8'h00, 2, 4}; run_vec(hv, 101);
        hv = '{OP_WR,    8'h11, 1'b0, 1'b0, 1'b1, 8'h55, 2, 4}; run_vec(hv, 102);
        hv = '{OP_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2, 4}; run_vec(hv, 103);
        chk("mismatch_sda_oe_cycles", oe_cnt, oe_mark);

        // Reset while the target drives the first (0) bit of 8'h7E.
        hv = '{OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2, 4}; run_vec(hv, 200);
        hv = '{OP_WR,    8'h85, 1'b1, 1'b1, 1'b0, 8'h00, 2, 5}; run_vec(hv, 201);
        for (int k = 0; k < 30; k++) begin
            if (sda_oe === 1'b1) break;
            wait_clk(1);
        end
        chk("rd_bit0_driven", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        chk("midrst_sda_oe",  32'(sda_oe),  32'd0);
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        wait_clk(2);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(10);
        hv = '{OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2, 5}; run_vec(hv, 202);
        hv = '{OP_WR,    8'h84, 1'b1, 1'b1, 1'b0, 8'h00, 2, 5}; run_vec(hv, 203);
        hv = '{OP_WR,    8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 3, 5}; run_vec(hv, 204);
        hv = '{OP_STOP,  8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 3, 5}; run_vec(hv, 205);

        chk("rx_valid_tx_req_overlap", overlap_cnt, 0);
        chk("rx_valid_width", long_rxv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
